// File: rtl/seq_restoring_divider.sv
// Radix-2 restoring divider: one quotient bit per clock behind valid/ready ports.
// Divide-by-zero short-circuits to DONE with quotient all-ones and remainder = dividend.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic             armed;
    logic [WIDTH-1:0] rem, dvd, dsr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   shifted;
    logic             ge, last, accept;
    logic [WIDTH-1:0] rem_nxt;

    // rem < dsr always holds, so the shifted partial remainder fits in WIDTH+1 bits
    // and the difference fits back into WIDTH bits whenever it is non-negative.
    assign shifted = {rem, dvd[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dsr};
    assign rem_nxt = ge ? (shifted[WIDTH-1:0] - dsr) : shifted[WIDTH-1:0];
    assign last    = (cnt == CNT_W'(WIDTH - 1));

    // armed keeps in_ready low until the first edge after reset release
    assign in_ready  = armed && (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (divisor == '0) ? DONE : RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed       <= 1'b0;
            rem         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                if (divisor == '0) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end else begin
                    dsr         <= divisor;
                    rem         <= '0;
                    dvd         <= dividend;
                    cnt         <= '0;
                    div_by_zero <= 1'b0;
                end
            end else if (state == RUN) begin
                rem <= rem_nxt;
                dvd <= {dvd[WIDTH-2:0], ge};
                cnt <= cnt + 1'b1;
                if (last) begin
                    quotient  <= {dvd[WIDTH-2:0], ge};
                    remainder <= rem_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: vector table, corner sequences and random pairs,
// with expected results queued at acceptance and checked when out_valid appears.
module tb_seq_restoring_divider;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic       in_ready, out_valid, div_by_zero;
    logic [7:0] dividend = '0, divisor = '0, quotient, remainder;

    int n_vec = 0, n_err = 0;

    typedef struct packed {logic [7:0] q; logic [7:0] r; logic dbz;} res_t;
    typedef struct {logic [7:0] a; logic [7:0] b; logic [7:0] q; logic [7:0] r; logic dbz;} vec_t;

    res_t sb[$];
    vec_t tbl[10];

    seq_restoring_divider #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                          input logic [7:0] r, input logic dbz, input int hold);
        int   w, lat;
        res_t e;
        w = 0;
        while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
        check("in_ready_before_accept", in_ready, 1);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        sb.push_back({q, r, dbz});
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check("latency", lat, (b == 0) ? 0 : 8);
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard: empty queue at result, expected an entry");
            e = '0;
        end else e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dbz);
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            dividend = 8'd9;
            divisor  = 8'd3;
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_quotient", quotient, e.q);
            check("hold_remainder", remainder, e.r);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_handshake_out_valid", out_valid, 0);
        check("post_handshake_in_ready", in_ready, 1);
    endtask

    initial begin
        tbl[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
        tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
        tbl[3] = '{8'd100, 8'd0,   8'd255, 8'd100, 1'b1};
        tbl[4] = '{8'd0,   8'd13,  8'd0,   8'd0,   1'b0};
        tbl[5] = '{8'd13,  8'd13,  8'd1,   8'd0,   1'b0};
        tbl[6] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        tbl[7] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
        tbl[8] = '{8'd255, 8'd2,   8'd127, 8'd1,   1'b0};
        tbl[9] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};

        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_div_by_zero", div_by_zero, 0);
        #10 rst = 1'b0;
        @(posedge clk); #1;
        check("first_edge_in_ready", in_ready, 1);

        foreach (tbl[i]) run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz, 0);

        // result held while the consumer stalls; operand pulses are ignored
        run_op(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 5);
        run_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 0);

        // asynchronous reset after four RUN iterations
        dividend = 8'd200;
        divisor  = 8'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_div_by_zero", div_by_zero, 0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        check("abort_recover_in_ready", in_ready, 1);
        run_op(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 0);

        for (int k = 0; k < 1000; k++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            run_op(a, b, a / b, a % b, 1'b0, 0);
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
